// File: rtl/memory_register_sink.sv
// Receiving end of the memoryRegister link: buffers (data, address) pairs in a small FIFO
// and drains one pair per cycle into a word memory that has a registered read port.
module memory_register_sink #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 16,
    parameter int MEM_WORDS  = 256,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] dataInput,
    input  logic [ADDR_W-1:0] dirrInput,
    input  logic              validInput,
    output logic              readyOutput,
    input  logic              readEn,
    input  logic [ADDR_W-1:0] readAddr,
    output logic [DATA_W-1:0] readData,
    output logic              readValid,
    output logic              busy,
    output logic [7:0]        errCount
);

    localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int MEM_AW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(FIFO_DEPTH);

    logic [DATA_W-1:0] fifo_data [FIFO_DEPTH];
    logic [ADDR_W-1:0] fifo_addr [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W:0]    count;

    logic [DATA_W-1:0] mem [MEM_WORDS];

    logic              push;
    logic              pop;
    logic [DATA_W-1:0] head_data;
    logic [ADDR_W-1:0] head_addr;
    logic              head_in_range;
    logic              rd_in_range;

    // Handshake: a pair transfers on a rising edge where validInput && readyOutput are both 1;
    // readyOutput depends only on the registered count, never on validInput.
    assign readyOutput = (count != FULL_CNT);
    assign busy        = (count != '0);
    assign push        = validInput && readyOutput;
    assign pop         = busy;

    assign head_data     = fifo_data[rd_ptr];
    assign head_addr     = fifo_addr[rd_ptr];
    // Full-width compare so high address bits never alias into the array.
    assign head_in_range = 32'(head_addr) < 32'(MEM_WORDS);
    assign rd_in_range   = 32'(readAddr) < 32'(MEM_WORDS);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            errCount  <= '0;
            readData  <= '0;
            readValid <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (pop && !head_in_range && (errCount != 8'hFF))
                errCount <= errCount + 1'b1;
            readValid <= readEn;
            // Sampled before this edge's drain write lands, so a same-address read sees old data.
            if (readEn)
                readData <= rd_in_range ? mem[readAddr[MEM_AW-1:0]] : '0;
        end
    end

    // Payload storage and memory carry no reset; pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data[wr_ptr] <= dataInput;
            fifo_addr[wr_ptr] <= dirrInput;
        end
        if (pop && head_in_range)
            mem[head_addr[MEM_AW-1:0]] <= head_data;
    end

endmodule
